// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg -- shared types for the CPU pipeline controller.
//   pctrl_state_t : controller states RUN / DMEM / HALT
//   regbits_t     : 5-bit architectural register index
//   sat_inc16     : saturating +1 for 16-bit event counters
package cpu_types_pkg;

   typedef logic [4:0] regbits_t;

   typedef enum logic [1:0] {
      RUN  = 2'd0,
      DMEM = 2'd1,
      HALT = 2'd2
   } pctrl_state_t;

   localparam logic [15:0] STALL_CNT_MAX = 16'hFFFF;

   // Counter increment that sticks at the maximum instead of wrapping.
   function automatic logic [15:0] sat_inc16(input logic [15:0] value);
      logic [15:0] result;
      if (value == STALL_CNT_MAX) begin
         result = value;
      end else begin
         result = value + 16'd1;
      end
      return result;
   endfunction

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// hazard_detect -- purely combinational load-use hazard comparator.
// Ports:
//   idex_memread in  ID/EX holds a load
//   idex_rt      in  load destination register
//   ifid_rs      in  IF/ID source register rs
//   ifid_rt      in  IF/ID source register rt
//   load_use     out 1 when the IF/ID instruction reads the pending load result
module hazard_detect
   import cpu_types_pkg::*;
(
   input  logic     idex_memread,
   input  regbits_t idex_rt,
   input  regbits_t ifid_rs,
   input  regbits_t ifid_rt,
   output logic     load_use
);

   // Register zero is hard-wired, so a load into it never creates a dependency.
   assign load_use = idex_memread
                   & (idex_rt != 5'd0)
                   & ((idex_rt == ifid_rs) | (idex_rt == ifid_rt));

endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl -- stall / flush / halt controller for a 5-stage pipeline
// sharing one memory port between instruction fetch and data access.
// Ports:
//   CLK, RST              clock, synchronous active-high reset
//   ihit, dhit            instruction / data access completed this cycle
//   dmemreq               EX/MEM holds a load or store
//   redirect              branch/jump resolved in MEM
//   idex_memread, idex_rt ID/EX load and its destination
//   ifid_rs, ifid_rt      IF/ID source registers
//   memwb_halt            halt instruction reached MEM/WB
//   pc_en .. memwb_en     latch enables (combinational)
//   *_flush               bubble insertion into IF/ID, ID/EX, EX/MEM (combinational)
//   iren                  instruction-port request (combinational)
//   halt                  registered halted flag
//   stall_cnt             registered saturating count of non-HALT cycles with pc_en = 0
module pipeline_ctrl
   import cpu_types_pkg::*;
(
   input  logic        CLK,
   input  logic        RST,
   input  logic        ihit,
   input  logic        dhit,
   input  logic        dmemreq,
   input  logic        redirect,
   input  logic        idex_memread,
   input  regbits_t    idex_rt,
   input  regbits_t    ifid_rs,
   input  regbits_t    ifid_rt,
   input  logic        memwb_halt,
   output logic        pc_en,
   output logic        ifid_en,
   output logic        idex_en,
   output logic        exmem_en,
   output logic        memwb_en,
   output logic        ifid_flush,
   output logic        idex_flush,
   output logic        exmem_flush,
   output logic        iren,
   output logic        halt,
   output logic [15:0] stall_cnt
);

   pctrl_state_t state_r;
   pctrl_state_t next_s;
   logic         halt_r;
   logic [15:0]  stall_cnt_r;
   logic         load_use_s;
   logic         dstall_s;
   logic         pc_en_s, ifid_en_s, idex_en_s, exmem_en_s, memwb_en_s;
   logic         ifid_flush_s, idex_flush_s, exmem_flush_s, iren_s;

   hazard_detect u_hazard_detect (
      .idex_memread (idex_memread),
      .idex_rt      (idex_rt),
      .ifid_rs      (ifid_rs),
      .ifid_rt      (ifid_rt),
      .load_use     (load_use_s)
   );

   assign dstall_s = dmemreq & ~dhit;

   // Next-state and per-cycle enable/flush decode, priority highest first.
   always_comb begin
      next_s        = state_r;
      pc_en_s       = 1'b0;
      ifid_en_s     = 1'b0;
      idex_en_s     = 1'b0;
      exmem_en_s    = 1'b0;
      memwb_en_s    = 1'b0;
      ifid_flush_s  = 1'b0;
      idex_flush_s  = 1'b0;
      exmem_flush_s = 1'b0;
      iren_s        = 1'b0;
      if (RST) begin
         next_s = RUN;
      end else begin
         case (state_r)
            RUN: begin
               // The data side owns the shared port whenever it is waiting.
               iren_s = ~dstall_s;
               if (memwb_halt) begin
                  next_s = HALT;
               end else if (dstall_s) begin
                  next_s = DMEM;
               end else if (redirect) begin
                  // Redirect outranks load-use: the flush removes the consumer.
                  {pc_en_s, ifid_en_s, idex_en_s, exmem_en_s, memwb_en_s} = 5'b11111;
                  {ifid_flush_s, idex_flush_s, exmem_flush_s}               = 3'b111;
               end else if (load_use_s) begin
                  {idex_en_s, exmem_en_s, memwb_en_s} = 3'b111;
                  idex_flush_s                        = 1'b1;
               end else if (!ihit) begin
                  {ifid_en_s, idex_en_s, exmem_en_s, memwb_en_s} = 4'b1111;
                  ifid_flush_s                                   = 1'b1;
               end else begin
                  {pc_en_s, ifid_en_s, idex_en_s, exmem_en_s, memwb_en_s} = 5'b11111;
               end
            end
            DMEM: begin
               if (memwb_halt) begin
                  next_s = HALT;
               end else if (dhit) begin
                  // Redirect is deliberately ignored here; it is seen again in RUN.
                  {pc_en_s, ifid_en_s, idex_en_s, exmem_en_s, memwb_en_s} = 5'b11111;
                  next_s = RUN;
               end else begin
                  next_s = DMEM;
               end
            end
            HALT: begin
               next_s = HALT;
            end
            default: begin
               next_s = RUN;
            end
         endcase
      end
   end

   // State, halt flag and saturating stall counter.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_r     <= RUN;
         halt_r      <= 1'b0;
         stall_cnt_r <= 16'd0;
      end else begin
         state_r <= next_s;
         halt_r  <= (next_s == HALT);
         if ((state_r != HALT) && !pc_en_s) begin
            stall_cnt_r <= sat_inc16(stall_cnt_r);
         end else begin
            stall_cnt_r <= stall_cnt_r;
         end
      end
   end

   assign pc_en       = pc_en_s;
   assign ifid_en     = ifid_en_s;
   assign idex_en     = idex_en_s;
   assign exmem_en    = exmem_en_s;
   assign memwb_en    = memwb_en_s;
   assign ifid_flush  = ifid_flush_s;
   assign idex_flush  = idex_flush_s;
   assign exmem_flush = exmem_flush_s;
   assign iren        = iren_s;
   assign halt        = halt_r;
   assign stall_cnt   = stall_cnt_r;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl -- directed-vector bench for pipeline_ctrl with a
// cycle-level behavioural model and a per-cycle compare process.
module tb_pipeline_ctrl;

   logic        CLK = 1'b0;
   logic        RST, ihit, dhit, dmemreq, redirect, idex_memread, memwb_halt;
   logic [4:0]  idex_rt, ifid_rs, ifid_rt;
   logic        pc_en, ifid_en, idex_en, exmem_en, memwb_en;
   logic        ifid_flush, idex_flush, exmem_flush, iren, halt;
   logic [15:0] stall_cnt;

   int total = 0;
   int bad   = 0;
   bit armed = 1'b0;

   // Model: "halted", "waiting on data" and the stall count as an int.
   bit m_halted  = 1'b0;
   bit m_waiting = 1'b0;
   int m_stalls  = 0;

   pipeline_ctrl dut (
      .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit), .dmemreq(dmemreq),
      .redirect(redirect), .idex_memread(idex_memread), .idex_rt(idex_rt),
      .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .memwb_halt(memwb_halt),
      .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
      .memwb_en(memwb_en), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
      .exmem_flush(exmem_flush), .iren(iren), .halt(halt), .stall_cnt(stall_cnt)
   );

   always #5 CLK = ~CLK;

   // Expected {pc,ifid,idex,exmem,memwb enables, ifid/idex/exmem flushes, iren}.
   function automatic logic [8:0] expect_outs();
      bit lu;
      bit data_wait;
      lu = idex_memread && (idex_rt != 5'd0) && (idex_rt == ifid_rs || idex_rt == ifid_rt);
      data_wait = dmemreq && !dhit;
      if (RST || m_halted)            return 9'b00000_000_0;
      if (memwb_halt)                 return {8'b00000_000, (!m_waiting && !data_wait)};
      if (m_waiting)                  return dhit ? 9'b11111_000_0 : 9'b00000_000_0;
      if (data_wait)                  return 9'b00000_000_0;
      if (redirect)                   return 9'b11111_111_1;
      if (lu)                         return 9'b00111_010_1;
      if (!ihit)                      return 9'b01111_100_1;
      return 9'b11111_000_1;
   endfunction

   task automatic check(input string name, input int actual, input int required);
      total++;
      if (actual != required) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", name, actual, required, $time);
      end
   endtask

   // Per-cycle compare of every DUT output against the model.
   always @(negedge CLK) begin
      if (armed) begin
         check("outs", {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                        ifid_flush, idex_flush, exmem_flush, iren}, expect_outs());
         check("halt", halt, m_halted);
         check("stall_cnt", stall_cnt, m_stalls);
      end
   end

   // Model update at each clock edge.
   always @(posedge CLK) begin
      logic [8:0] e;
      e = expect_outs();
      if (RST) begin
         m_halted  <= 1'b0;
         m_waiting <= 1'b0;
         m_stalls  <= 0;
      end else if (!m_halted) begin
         if (!e[8]) m_stalls <= (m_stalls >= 65535) ? 65535 : m_stalls + 1;
         if (memwb_halt) begin
            m_halted  <= 1'b1;
            m_waiting <= 1'b0;
         end else if (m_waiting) begin
            m_waiting <= !dhit;
         end else begin
            m_waiting <= dmemreq && !dhit;
         end
      end
   end

   task automatic adv();
      @(posedge CLK);
      #1;
   endtask

   initial begin
      RST = 1'b1; ihit = 1'b1; dhit = 1'b0; dmemreq = 1'b0; redirect = 1'b0;
      idex_memread = 1'b0; memwb_halt = 1'b0;
      idex_rt = 5'd0; ifid_rs = 5'd0; ifid_rt = 5'd0;
      adv();
      armed = 1'b1;
      @(negedge CLK);
      check("rst_pc_en", pc_en, 0); check("rst_iren", iren, 0);
      check("rst_halt", halt, 0);   check("rst_cnt", stall_cnt, 0);
      adv(); RST = 1'b0;
      @(negedge CLK);
      check("norm_pc_en", pc_en, 1); check("norm_iren", iren, 1);
      // load-use
      adv(); idex_memread = 1'b1; idex_rt = 5'd5; ifid_rs = 5'd5; ifid_rt = 5'd7;
      @(negedge CLK);
      check("lu_pc_en", pc_en, 0); check("lu_ifid_en", ifid_en, 0);
      check("lu_idex_flush", idex_flush, 1); check("lu_memwb_en", memwb_en, 1);
      adv(); idex_rt = 5'd0; ifid_rs = 5'd0;
      @(negedge CLK);
      check("lu_cnt", stall_cnt, 1); check("r0_no_stall", pc_en, 1);
      // dmem wait: three miss cycles then a hit
      adv(); idex_memread = 1'b0; dmemreq = 1'b1; dhit = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge CLK);
         check("dw_exmem_en", exmem_en, 0); check("dw_iren", iren, 0);
         adv();
      end
      dhit = 1'b1;
      @(negedge CLK);
      check("dw_hit_pc_en", pc_en, 1); check("dw_hit_memwb_en", memwb_en, 1);
      // redirect with imiss and a simultaneous load-use hazard
      adv(); dmemreq = 1'b0; dhit = 1'b0; redirect = 1'b1; ihit = 1'b0;
      idex_memread = 1'b1; idex_rt = 5'd9; ifid_rt = 5'd9;
      @(negedge CLK);
      check("dw_cnt", stall_cnt, 4);
      check("rd_flushes", {ifid_flush, idex_flush, exmem_flush}, 7);
      check("rd_pc_en", pc_en, 1); check("rd_idex_en", idex_en, 1);
      // plain imiss
      adv(); redirect = 1'b0; idex_memread = 1'b0;
      @(negedge CLK);
      check("im_pc_en", pc_en, 0); check("im_ifid_flush", ifid_flush, 1);
      check("im_ifid_en", ifid_en, 1);
      // halt raised during a dmem stall
      adv(); ihit = 1'b1; dmemreq = 1'b1; dhit = 1'b0;
      adv(); memwb_halt = 1'b1;
      @(negedge CLK);
      check("hl_enables", {pc_en, ifid_en, idex_en, exmem_en, memwb_en}, 0);
      check("hl_not_yet", halt, 0);
      adv(); memwb_halt = 1'b0; dmemreq = 1'b0; ihit = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge CLK);
         check("hl_sticky", halt, 1); check("hl_cnt", stall_cnt, 7);
         check("hl_pc_en", pc_en, 0);
         adv();
      end
      RST = 1'b1;
      adv(); RST = 1'b0; ihit = 1'b1;
      @(negedge CLK);
      check("hl_rst_halt", halt, 0); check("hl_rst_cnt", stall_cnt, 0);
      check("hl_rst_run", pc_en, 1);
      // redirect on the DMEM exit cycle is deferred to the next RUN cycle
      adv(); dmemreq = 1'b1; dhit = 1'b0;
      adv(); dhit = 1'b1; redirect = 1'b1;
      @(negedge CLK);
      check("dx_no_flush", {ifid_flush, idex_flush, exmem_flush}, 0);
      adv(); dmemreq = 1'b0; dhit = 1'b0;
      @(negedge CLK);
      check("dx_flush", {ifid_flush, idex_flush, exmem_flush}, 7);
      // saturation
      adv(); redirect = 1'b0; ihit = 1'b0;
      repeat (70000) adv();
      @(negedge CLK);
      check("sat", stall_cnt, 16'hFFFF);
      repeat (5) adv();
      @(negedge CLK);
      check("sat_hold", stall_cnt, 16'hFFFF);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
